// File: rtl/seg_scan_decoder.sv
// Reads back the multiplexed seven-segment bus, decodes each settled digit dwell and
// publishes complete 4-digit frames, flagging illegal patterns and a stalled scan.
module seg_scan_decoder #(
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  sel_in,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        stale
);

  localparam logic [8:0]  SETTLE_N = 9'(SETTLE);
  localparam logic [23:0] T_MAX    = 24'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_BLANK, S_SETTLE, S_HOLD} state_t;

  logic [7:0]  seg_q;
  logic [3:0]  sel_q;
  state_t      state;
  logic [7:0]  cnt;
  logic [11:0] ref_q;
  logic [3:0]  seen;
  logic [3:0]  seen_nx;
  logic [3:0]  slot_val [4];
  logic [3:0]  slot_dp;
  logic [23:0] tcount;
  logic [23:0] tcount_nx;

  logic [11:0] samp;
  logic        sel_legal;
  logic        match;
  logic        capture;
  logic        frame_done;
  logic [8:0]  cnt_inc;
  logic [1:0]  slot;
  logic [3:0]  dec_val;
  logic        dec_err;

  // Returns {illegal, value}; a fully dark digit reads back as F without an error.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h10:   decode = 5'h09;
      7'h7F:   decode = 5'h0F;
      default: decode = 5'h1E;
    endcase
  endfunction

  always_ff @(posedge sysclock) begin
    if (!reset) begin
      seg_q <= 8'hFF;
      sel_q <= 4'hF;
    end else begin
      seg_q <= seg_in;
      sel_q <= sel_in;
    end
  end

  // A capture always uses the current sample: either it matches ref or it becomes the new ref.
  always_comb begin
    samp      = {sel_q, seg_q};
    sel_legal = $onehot(~sel_q);
    match     = (samp == ref_q);
    cnt_inc   = {1'b0, cnt} + 9'd1;
    {dec_err, dec_val} = decode(seg_q[6:0]);
    capture   = 1'b0;
    case (state)
      S_BLANK:  capture = sel_legal && (SETTLE_N == 9'd1);
      S_SETTLE: capture = match ? (cnt_inc == SETTLE_N)
                                : (sel_legal && (SETTLE_N == 9'd1));
      S_HOLD:   capture = !match && sel_legal && (SETTLE_N == 9'd1);
      default:  capture = 1'b0;
    endcase
    case (sel_q)
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot = 2'd0;
    endcase
    frame_done = (seen == 4'hF);
    seen_nx    = frame_done ? 4'h0 : seen;
    if (capture) seen_nx = seen_nx | (4'b0001 << slot);
    if (clear)   seen_nx = 4'h0;
    tcount_nx  = (tcount == T_MAX) ? tcount : tcount + 24'd1;
  end

  always_ff @(posedge sysclock) begin
    if (!reset) begin
      state <= S_BLANK;
      cnt   <= 8'd0;
      ref_q <= 12'h000;
    end else begin
      case (state)
        S_BLANK: begin
          if (sel_legal) begin
            ref_q <= samp;
            cnt   <= 8'd1;
            state <= capture ? S_HOLD : S_SETTLE;
          end
        end
        S_SETTLE, S_HOLD: begin
          if (match) begin
            if (state == S_SETTLE) begin
              cnt <= cnt_inc[7:0];
              if (capture) state <= S_HOLD;
            end
          end else if (sel_legal) begin
            ref_q <= samp;
            cnt   <= 8'd1;
            state <= capture ? S_HOLD : S_SETTLE;
          end else begin
            state <= S_BLANK;
          end
        end
        default: state <= S_BLANK;
      endcase
    end
  end

  // Frame publish reads the slot registers before this edge's capture lands in them.
  always_ff @(posedge sysclock) begin
    if (!reset) begin
      seen        <= 4'h0;
      slot_dp     <= 4'h0;
      for (int i = 0; i < 4; i++) slot_val[i] <= 4'h0;
      digits      <= 16'h0000;
      dp          <= 4'h0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      seen        <= seen_nx;
      frame_valid <= frame_done;
      if (capture) begin
        slot_val[slot] <= dec_val;
        slot_dp[slot]  <= ~seg_q[7];
      end
      if (frame_done) begin
        digits <= {slot_val[3], slot_val[2], slot_val[1], slot_val[0]};
        dp     <= slot_dp;
      end
      if (capture && dec_err) pattern_err <= 1'b1;
      else if (clear)         pattern_err <= 1'b0;
    end
  end

  always_ff @(posedge sysclock) begin
    if (!reset) begin
      tcount <= 24'd0;
      stale  <= 1'b0;
    end else if (frame_done) begin
      tcount <= 24'd0;
      stale  <= 1'b0;
    end else begin
      tcount <= tcount_nx;
      stale  <= (tcount_nx == T_MAX);
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Readback and monitor block for the 4-digit multiplexed seven-segment display path.
- Samples the active-low segment bus and the active-low digit-select bus that drive the display.
- Waits for each digit dwell to settle, then decodes the segment pattern back to a 4-bit value. Once all four digit slots have been captured, it publishes them as one frame.
- Flags illegal patterns and a stalled scan; used for self-check of the counter/display chain.

Parameters:
SETTLE, 8, consecutive identical samples required before a digit is captured (legal range 1..255; 8-bit counter)
TIMEOUT, 1000000, cycles without a completed frame before stale asserts (24-bit counter)

Ports:
sysclock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
seg_in  input  8  display segment bus, active-low; [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp
sel_in  input  4  digit select, active-low one-hot; bit i low selects digit i
clear  input  1  synchronous clear of pattern_err and the partial-frame capture set
digits  output  16  last complete frame; digit i is at [4i+3:4i]
dp  output  4  decimal point per digit of the last frame, active-high (equals ~seg_in[7] at capture)
frame_valid  output  1  one-cycle pulse; digits and dp updated in the same cycle
pattern_err  output  1  sticky; an illegal segment pattern was captured
stale  output  1  no frame completed within TIMEOUT cycles

Behaviour:
- Input stage: seg_in and sel_in are registered once (seg_q, sel_q). All decisions use the registered values.
- Reset (reset low at an edge):
  - state=BLANK, settle count=0, seen=4'b0000, timeout count=0.
  - digits=16'h0000, dp=4'h0, frame_valid=0, pattern_err=0, stale=0.
  - Reset mid-dwell discards all partial captures.
- Selector legality: sel_q is legal only when exactly one bit is 0. All-ones (blanking) or more than one bit low is illegal.
- FSM states: BLANK, SETTLE, HOLD.
  - BLANK, illegal sel_q: stay in BLANK.
  - BLANK, legal sel_q: latch ref={sel_q,seg_q}, set cnt=1, go to SETTLE.
  - SETTLE, {sel_q,seg_q}==ref: increment cnt. When the increment reaches SETTLE, capture and go to HOLD. If SETTLE=1, capture on the BLANK->SETTLE edge.
  - SETTLE or HOLD, sample differs from ref and is legal: reload ref, set cnt=1, go to SETTLE. This covers a segment glitch restarting the dwell.
  - SETTLE or HOLD, sample differs from ref and is illegal: go to BLANK.
  - HOLD, sample equals ref: stay in HOLD, no further capture. Exactly one capture per dwell.
- Capture, for slot i = index of the low bit in ref sel:
  - Write the slot digit and dp, set seen[i]. A repeat capture of the same slot before the frame completes overwrites it (latest wins).
  - Decode of seg[6:0] (g..a), active-low:
    - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
    - 7F (blank) -> 4'hF, no error.
    - Any other value -> 4'hE and set pattern_err.
- Frame completion:
  - When a capture makes seen==4'b1111, on the next edge: digits/dp load all four slots, frame_valid=1 for one cycle, seen clears.
  - Timing: with inputs constant from sampling edge 0, frame_valid is high in the cycle after edge SETTLE+1.
- clear:
  - Clears pattern_err and seen.
  - Same cycle as a capture: the capture's seen bit is discarded.
  - Same cycle as an illegal-pattern capture: pattern_err ends at 1 (set wins).
  - digits, dp and stale are unaffected.
- Stale:
  - The timeout counter increments every cycle and resets to 0 on frame_valid.
  - When it reaches TIMEOUT-1, stale=1. The counter saturates there.
  - stale clears on the next frame_valid.
- The selector order is irrelevant; any scan order completes a frame once all four slots are seen.

Test Plan:
- Reset hold then release, no stimulus -> digits=0000, dp=0, frame_valid=0, pattern_err=0; after TIMEOUT cycles stale=1.
- Scan sel 1110,1101,1011,0111 with seg 8'hF9,8'hA4,8'hB0,8'h99, each held 20 cycles (SETTLE=8) -> single frame_valid pulse after the 4th dwell; digits=16'h4321, dp=0; stale clears.
- Digit 0 pattern 8'h40 (dp lit) with seg toggled to 8'h79 at dwell cycle 5, then restored -> SETTLE restarts; captured value=0 with dp[0]=1, no 1 captured.
- Dwell of SETTLE-1 cycles on one slot between valid dwells of the others -> that slot not seen, no frame_valid until a full-length dwell occurs.
- seg 8'hFF on slot 2 and 8'hAA on slot 3 -> frame digits[11:8]=F, digits[15:12]=E, pattern_err=1 held; clear pulse -> pattern_err=0, digits unchanged.
- sel_in=4'b1100 (two low) mid-dwell, and reset asserted mid-frame -> FSM to BLANK, no capture; after reset seen=0, and a new full scan is required for frame_valid.
